uart_rx_phy: RTL
================

Name: uart_rx_phy

Overview:
- Serial-to-parallel receive PHY for the UART peripheral; the receiving end of the transmit frame format (start, 8 data LSB-first, optional parity, 1 or 2 stop bits).
- Sits between the external rxd pin and the UART register/FIFO layer.
- Runs from the system clock with a programmable cycles-per-bit divisor.
- Delivers each received byte with per-frame parity and framing error flags.

Parameters:
- DIV_WIDTH, 16, width of the cycles-per-bit divisor input.
- SYNC_STAGES, 2, flip-flop stages in the rxd synchronizer (minimum 2).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx_enable  input  1  receiver enable; low forces Idle.
- rxd  input  1  asynchronous serial line; idles high.
- div  input  DIV_WIDTH  clock cycles per bit.
- parity_type  input  2  00 = none, 01 = even, 10 = odd, 11 = none.
- nstop  input  1  0 = one stop bit, 1 = two stop bits.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse when a frame completes.
- parity_error  output  1  parity mismatch on the last frame.
- frame_error  output  1  stop bit sampled low on the last frame.
- busy  output  1  high whenever state != Idle.

Behaviour:
- Reset: state = Idle; all counters 0; synchronizer stages 1 (line-idle value). Outputs: rx_data = 0, rx_valid = 0, parity_error = 0, frame_error = 0, busy = 0.
- Synchronizer: rxd passes through SYNC_STAGES flops to give rxd_s. rxd_q is a 1-cycle-delayed copy of rxd_s, used for edge detection.
- Latched configuration: div, parity_type and nstop are latched at start detection and used for the whole frame. Changes mid-frame are ignored. A div value below 4 is latched as 4.
- Counters: cnt is DIV_WIDTH bits and is cleared on every bit transition. bit_idx is 3 bits.
- Idle:
  - Start detection requires rx_enable = 1 and a falling edge (rxd_q = 1, rxd_s = 0).
  - On detection: go to Start, cnt = 0.
  - A level-low line with no falling edge, such as a held break, never starts a frame.
- Start:
  - cnt increments each cycle.
  - At cnt == div>>1, sample rxd_s.
  - If 1: false start, return to Idle with no rx_valid.
  - If 0: go to Data, cnt = 0, bit_idx = 0.
- Data:
  - At cnt == div-1, sample rxd_s into shift register bit bit_idx (LSB first) and set cnt = 0.
  - After bit_idx == 7, go to Parity if parity is enabled, else Stop1.
- Parity:
  - At cnt == div-1, sample the parity bit.
  - perr = (XOR of data bits ^ sampled bit) != (parity_type == odd).
  - Go to Stop1.
- Stop1:
  - At cnt == div-1, sample rxd_s.
  - If 0: frame completes now with frame_error = 1; Stop2 is skipped even when nstop = 1.
  - If 1 and nstop = 1: go to Stop2.
  - If 1 and nstop = 0: frame completes.
- Stop2:
  - At cnt == div-1, sample rxd_s.
  - Frame completes, with frame_error = ~sample.
- Frame completion (registered, takes effect the cycle after the completing sample):
  - rx_valid = 1 for exactly one cycle.
  - rx_data, parity_error and frame_error update together and then hold until the next completion.
  - parity_error is 0 when parity is disabled.
  - State returns to Idle in the same cycle, so the next start edge may arrive in the second half of the stop bit.
- rx_enable deasserted mid-frame: next cycle state = Idle. No rx_valid; rx_data and error flags are unchanged.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded.
- Latency: rx_valid rises SYNC_STAGES + 1 + (div>>1) + N*div + 1 cycles (±1) after the rxd falling edge. N = number of bits after start (8 data + parity + stop bits sampled).

Test Plan:
- Basic frame: div = 16, no parity, nstop = 0, send 0x55 -> one rx_valid pulse about 156 cycles after the start edge; rx_data = 0x55; both error flags 0.
- Parity: even parity, send 0xA3 (four 1s) with parity bit 0 -> parity_error = 0. Repeat with parity bit 1 -> parity_error = 1 and rx_data = 0xA3.
- Framing: send 0x0F with stop bit driven low, nstop = 1 -> rx_valid in Stop1, frame_error = 1, Stop2 not entered. Next frame 0x3C with valid stop bits -> frame_error = 0.
- Glitch: 4-cycle low pulse on rxd with div = 16 -> busy high, then back to Idle; no rx_valid.
- Back-to-back: two frames 0x12, 0x34 with the second start edge 2 cycles after the first stop-bit midpoint (nstop = 0) -> two rx_valid pulses with correct bytes.
- Abort: deassert rx_enable during bit 4 of 0xFF -> busy = 0 next cycle; no rx_valid; rx_data keeps its prior value.
- Reset: assert reset_n low during Parity -> all outputs 0 immediately. A following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_phy.sv
// UART receive PHY: synchronises rxd, finds the start edge, samples each bit at its centre
// and hands the byte upward with parity/framing status on a one-cycle rx_valid pulse.
module uart_rx_phy #(
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx_enable,
    input  logic                 rxd,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [1:0]           parity_type,
    input  logic                 nstop,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(4);

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxdQ;
    logic [DIV_WIDTH-1:0]   r_div;
    logic [1:0]             r_parType;
    logic                   r_nstop;
    logic [DIV_WIDTH-1:0]   r_cnt;
    logic [2:0]             r_bitIdx;
    logic [7:0]             r_shift;
    logic                   r_perrPend;
    logic [7:0]             r_rxData;
    logic                   r_rxValid;
    logic                   r_parityError;
    logic                   r_frameError;

    logic w_rxdS;
    logic w_startDet;
    logic w_bitTick;
    logic w_halfTick;
    logic w_parEn;
    logic w_perr;
    logic w_done;
    logic w_ferr;

    assign w_rxdS     = r_sync[SYNC_STAGES-1];
    assign w_startDet = (r_state == IDLE) && rx_enable && r_rxdQ && !w_rxdS;
    assign w_bitTick  = (r_cnt == r_div - DIV_WIDTH'(1));
    assign w_halfTick = (r_cnt == (r_div >> 1));
    assign w_parEn    = (r_parType == 2'b01) || (r_parType == 2'b10);
    assign w_perr     = ((^r_shift) ^ w_rxdS) != (r_parType == 2'b10);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '1;
            r_rxdQ <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_rxdQ <= w_rxdS;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startDet) w_stateNext = START;
            end
            START: begin
                if (w_halfTick) w_stateNext = w_rxdS ? IDLE : DATA;
            end
            DATA: begin
                if (w_bitTick && (r_bitIdx == 3'd7)) w_stateNext = w_parEn ? PARITY : STOP1;
            end
            PARITY: begin
                if (w_bitTick) w_stateNext = STOP1;
            end
            STOP1: begin
                if (w_bitTick) begin
                    if (!w_rxdS) begin
                        // A low first stop bit ends the frame at once; a second stop bit is never checked.
                        w_done      = 1'b1;
                        w_ferr      = 1'b1;
                        w_stateNext = IDLE;
                    end else if (r_nstop) begin
                        w_stateNext = STOP2;
                    end else begin
                        w_done      = 1'b1;
                        w_stateNext = IDLE;
                    end
                end
            end
            STOP2: begin
                if (w_bitTick) begin
                    w_done      = 1'b1;
                    w_ferr      = !w_rxdS;
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
        if (!rx_enable) begin
            w_stateNext = IDLE;
            w_done      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div         <= '0;
            r_parType     <= 2'b00;
            r_nstop       <= 1'b0;
            r_cnt         <= '0;
            r_bitIdx      <= 3'd0;
            r_shift       <= 8'h00;
            r_perrPend    <= 1'b0;
            r_rxData      <= 8'h00;
            r_rxValid     <= 1'b0;
            r_parityError <= 1'b0;
            r_frameError  <= 1'b0;
        end else begin
            r_rxValid <= w_done;
            if (w_startDet) begin
                r_div      <= (div < MIN_DIV) ? MIN_DIV : div;
                r_parType  <= parity_type;
                r_nstop    <= nstop;
                r_cnt      <= '0;
                r_perrPend <= 1'b0;
            end else begin
                case (r_state)
                    START: begin
                        if (w_halfTick) begin
                            r_cnt    <= '0;
                            r_bitIdx <= 3'd0;
                        end else begin
                            r_cnt <= r_cnt + DIV_WIDTH'(1);
                        end
                    end
                    DATA: begin
                        if (w_bitTick) begin
                            r_shift[r_bitIdx] <= w_rxdS;
                            r_bitIdx          <= r_bitIdx + 3'd1;
                            r_cnt             <= '0;
                        end else begin
                            r_cnt <= r_cnt + DIV_WIDTH'(1);
                        end
                    end
                    PARITY: begin
                        if (w_bitTick) begin
                            r_perrPend <= w_perr;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt <= r_cnt + DIV_WIDTH'(1);
                        end
                    end
                    STOP1, STOP2: begin
                        r_cnt <= w_bitTick ? '0 : r_cnt + DIV_WIDTH'(1);
                    end
                    default: r_cnt <= '0;
                endcase
            end
            if (w_done) begin
                r_rxData      <= r_shift;
                r_parityError <= w_parEn && r_perrPend;
                r_frameError  <= w_ferr;
            end
        end
    end

    assign rx_data      = r_rxData;
    assign rx_valid     = r_rxValid;
    assign parity_error = r_parityError;
    assign frame_error  = r_frameError;
    assign busy         = (r_state != IDLE);

endmodule
